// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes, the
// write/read handshake state encodings, the default ID word and a helper
// that expands byte strobes into a bit mask.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA11E_0001;

  // Each strobe bit covers one byte lane of the 32-bit word.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address to register index decoder.
// err_o flags a misaligned address or one that lies past the last register.
module axi4_lite_addr_decode #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [31:0]      addr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             err_o
);

  assign idx_o = addr_i[IDX_W+1:2];
  assign err_o = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= NUM_REGS);

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; the last one is a
// read-only ID word. Write and read channels run independent FSMs with one
// outstanding transaction each.
// Optional feature: define AXI4_LITE_SLV_WSTRB_EN to honour wstrb byte lanes;
// without it every accepted write replaces the full word.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     awvalid_i,
  output logic                     awready_o,
  input  logic [31:0]              awaddr_i,
  input  logic                     wvalid_i,
  output logic                     wready_o,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               wstrb_i,
  output logic                     bvalid_o,
  input  logic                     bready_i,
  output logic [1:0]               bresp_o,
  input  logic                     arvalid_i,
  output logic                     arready_o,
  input  logic [31:0]              araddr_i,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  output logic [31:0]              rdata_o,
  output logic [1:0]               rresp_o,
  output logic [NUM_REGS*32-1:0]   regs_o
);

  localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned STORE_N = NUM_REGS - 1;

  w_state_e         wrState_q, wrState_d;
  logic [31:0]      awaddrHeld_q, awaddrHeld_d;
  logic [31:0]      wdataHeld_q, wdataHeld_d;
  logic [3:0]       wstrbHeld_q, wstrbHeld_d;
  resp_e            bresp_q, bresp_d;
  logic [31:0]      store_q [STORE_N];
  logic [31:0]      store_d [STORE_N];

  r_state_e         rdState_q, rdState_d;
  logic [31:0]      rdata_q, rdata_d;
  resp_e            rresp_q, rresp_d;

  logic             awHs, wHs, arHs;
  logic [31:0]      wrAddr, wrData, wrMask;
  logic [3:0]       wrStrb;
  logic [IDX_W-1:0] wrIdx, rdIdx;
  logic             wrErr, rdErr, wrReject, wrCommit;
  logic [31:0]      regFile [NUM_REGS];
  logic [31:0]      rdSel;

  // Ready lines are forced low while reset is held so nothing is accepted.
  assign awready_o = !rst_i && ((wrState_q == W_IDLE) || (wrState_q == W_WAIT_AW));
  assign wready_o  = !rst_i && ((wrState_q == W_IDLE) || (wrState_q == W_WAIT_W));
  assign arready_o = !rst_i && (rdState_q == R_IDLE);

  assign awHs = awvalid_i && awready_o;
  assign wHs  = wvalid_i && wready_o;
  assign arHs = arvalid_i && arready_o;

  // Whichever half of the write arrived first was parked in a holding register.
  assign wrAddr = (wrState_q == W_WAIT_W)  ? awaddrHeld_q : awaddr_i;
  assign wrData = (wrState_q == W_WAIT_AW) ? wdataHeld_q  : wdata_i;
  assign wrStrb = (wrState_q == W_WAIT_AW) ? wstrbHeld_q  : wstrb_i;

`ifdef AXI4_LITE_SLV_WSTRB_EN
  assign wrMask = strb_to_mask(wrStrb);
`else
  // Strobes are overridden so every write covers the full word.
  assign wrMask = strb_to_mask(wrStrb | 4'hF);
`endif

  axi4_lite_addr_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_wr_decode (
    .addr_i (wrAddr),
    .idx_o  (wrIdx),
    .err_o  (wrErr)
  );

  axi4_lite_addr_decode #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rd_decode (
    .addr_i (araddr_i),
    .idx_o  (rdIdx),
    .err_o  (rdErr)
  );

  assign wrReject = wrErr || (wrIdx == IDX_W'(NUM_REGS - 1));

  // Write FSM: pair up AW and W in either order, commit, then hold the response.
  always_comb begin
    wrState_d    = wrState_q;
    awaddrHeld_d = awaddrHeld_q;
    wdataHeld_d  = wdataHeld_q;
    wstrbHeld_d  = wstrbHeld_q;
    bresp_d      = bresp_q;
    wrCommit     = 1'b0;
    case (wrState_q)
      W_IDLE: begin
        if (awHs && wHs) begin
          wrCommit  = 1'b1;
          wrState_d = W_RESP;
        end else if (awHs) begin
          awaddrHeld_d = awaddr_i;
          wrState_d    = W_WAIT_W;
        end else if (wHs) begin
          wdataHeld_d = wdata_i;
          wstrbHeld_d = wstrb_i;
          wrState_d   = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (wHs) begin
          wrCommit  = 1'b1;
          wrState_d = W_RESP;
        end
      end
      W_WAIT_AW: begin
        if (awHs) begin
          wrCommit  = 1'b1;
          wrState_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          wrState_d = W_IDLE;
        end
      end
      default: wrState_d = W_IDLE;
    endcase
    if (wrCommit) begin
      bresp_d = wrReject ? SLVERR : OKAY;
    end
  end

  // Register file next state: masked merge into the addressed writable register.
  always_comb begin
    for (int i = 0; i < int'(STORE_N); i++) begin
      store_d[i] = store_q[i];
      if (wrCommit && !wrReject && (wrIdx == IDX_W'(i))) begin
        store_d[i] = (store_q[i] & ~wrMask) | (wrData & wrMask);
      end
    end
  end

  // Full register view with the constant ID word in the top slot.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regFile[i] = (i == int'(NUM_REGS) - 1) ? ID_VALUE : store_q[i];
    end
  end

  // Read data multiplexer over the register view.
  always_comb begin
    rdSel = 32'h0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rdIdx == IDX_W'(i)) begin
        rdSel = regFile[i];
      end
    end
  end

  // Read FSM: capture data on address handshake, hold it until rready.
  always_comb begin
    rdState_d = rdState_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rdState_q)
      R_IDLE: begin
        if (arHs) begin
          rdState_d = R_RESP;
          rdata_d   = rdErr ? 32'h0 : rdSel;
          rresp_d   = rdErr ? SLVERR : OKAY;
        end
      end
      R_RESP: begin
        if (rready_i) begin
          rdState_d = R_IDLE;
        end
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrState_q    <= W_IDLE;
      awaddrHeld_q <= 32'h0;
      wdataHeld_q  <= 32'h0;
      wstrbHeld_q  <= 4'h0;
      bresp_q      <= OKAY;
      rdState_q    <= R_IDLE;
      rdata_q      <= 32'h0;
      rresp_q      <= OKAY;
      for (int i = 0; i < int'(STORE_N); i++) begin
        store_q[i] <= 32'h0;
      end
    end else begin
      wrState_q    <= wrState_d;
      awaddrHeld_q <= awaddrHeld_d;
      wdataHeld_q  <= wdataHeld_d;
      wstrbHeld_q  <= wstrbHeld_d;
      bresp_q      <= bresp_d;
      rdState_q    <= rdState_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      for (int i = 0; i < int'(STORE_N); i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  assign bvalid_o = (wrState_q == W_RESP);
  assign bresp_o  = bresp_q;
  assign rvalid_o = (rdState_q == R_RESP);
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
    assign regs_o[g*32 +: 32] = regFile[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed testbench for axi4_lite_slave_regs (default 8 registers, ID in slot 7).
// Expected values follow the optional AXI4_LITE_SLV_WSTRB_EN build when defined.
module tb_axi4_lite_slave_regs;

  localparam int unsigned NUM_REGS = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   awvalid, awready;
  logic [31:0]            awaddr;
  logic                   wvalid, wready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   bvalid, bready;
  logic [1:0]             bresp;
  logic                   arvalid, arready;
  logic [31:0]            araddr;
  logic                   rvalid, rready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic [NUM_REGS*32-1:0] regs;

  int testsRun    = 0;
  int testsFailed = 0;

  axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ID_VALUE(32'hA11E_0001)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .awaddr_i  (awaddr),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .bvalid_o  (bvalid),
    .bready_i  (bready),
    .bresp_o   (bresp),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .araddr_i  (araddr),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .rdata_o   (rdata),
    .rresp_o   (rresp),
    .regs_o    (regs)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Advance one cycle and land just after the edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same-cycle write followed by a response handshake; reports what came back.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] respSeen);
    awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    respSeen = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b0;
    tick();
    tick();
    testsRun++;
    if ({awready, wready, arready} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_readys: got %b expected %b", {awready, wready, arready}, 3'b000);
    end
    testsRun++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
      testsFailed++; $display("[TB] FAIL reset_resp: got %b expected %b", {bvalid, rvalid, bresp, rresp}, 6'b0);
    end
    testsRun++;
    if (rdata !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 32'h0);
    end
    testsRun++;
    if (regs[223:0] !== 224'h0) begin
      testsFailed++; $display("[TB] FAIL reset_regs: got %h expected %h", regs[223:0], 224'h0);
    end
    testsRun++;
    if (regs[255:224] !== 32'hA11E_0001) begin
      testsFailed++; $display("[TB] FAIL reset_id: got %h expected %h", regs[255:224], 32'hA11E_0001);
    end
    rst = 1'b0;
    tick();
    testsRun++;
    if ({awready, wready, arready} !== 3'b111) begin
      testsFailed++; $display("[TB] FAIL reset_release_readys: got %b expected %b", {awready, wready, arready}, 3'b111);
    end
  endtask

  task automatic test_same_cycle();
    awvalid = 1'b1; awaddr = 32'h04; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    testsRun++;
    if ({bvalid, bresp} !== 3'b100) begin
      testsFailed++; $display("[TB] FAIL same_bvalid_bresp: got %b expected %b", {bvalid, bresp}, 3'b100);
    end
    testsRun++;
    if (regs[63:32] !== 32'hDEAD_BEEF) begin
      testsFailed++; $display("[TB] FAIL same_reg1: got %h expected %h", regs[63:32], 32'hDEAD_BEEF);
    end
    // New AW/W offered while the response is pending must be ignored.
    awvalid = 1'b1; awaddr = 32'h08; wvalid = 1'b1; wdata = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      tick();
      testsRun++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        testsFailed++; $display("[TB] FAIL resp_hold_%0d: got %b expected %b", c, {bvalid, bresp, awready, wready}, 5'b10000);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    testsRun++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      testsFailed++; $display("[TB] FAIL resp_release: got %b expected %b", {bvalid, awready, wready}, 3'b011);
    end
    testsRun++;
    if (regs[95:64] !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL resp_ignored_write: got %h expected %h", regs[95:64], 32'h0);
    end
  endtask

  task automatic test_w_first();
    wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; awaddr = 32'h08;
    testsRun++;
    if (wready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL wfirst_wready0: got %b expected %b", wready, 1'b1);
    end
    tick();
    // Keep offering different data; it must not replace the held word.
    wdata = 32'hFFFF_FFFF;
    for (int c = 1; c <= 3; c++) begin
      testsRun++;
      if ({wready, awready, bvalid} !== 3'b010) begin
        testsFailed++; $display("[TB] FAIL wfirst_wait_c%0d: got %b expected %b", c, {wready, awready, bvalid}, 3'b010);
      end
      if (c < 3) tick();
    end
    wvalid = 1'b0; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    testsRun++;
    if ({bvalid, bresp} !== 3'b100) begin
      testsFailed++; $display("[TB] FAIL wfirst_bvalid_c4: got %b expected %b", {bvalid, bresp}, 3'b100);
    end
    testsRun++;
    if (regs[95:64] !== 32'h1234_5678) begin
      testsFailed++; $display("[TB] FAIL wfirst_reg2: got %h expected %h", regs[95:64], 32'h1234_5678);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_aw_first();
    awvalid = 1'b1; awaddr = 32'h0C;
    tick();
    awvalid = 1'b0; awaddr = 32'h00;
    testsRun++;
    if ({awready, wready, bvalid} !== 3'b010) begin
      testsFailed++; $display("[TB] FAIL awfirst_wait: got %b expected %b", {awready, wready, bvalid}, 3'b010);
    end
    tick();
    wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    testsRun++;
    if ({bvalid, bresp} !== 3'b100) begin
      testsFailed++; $display("[TB] FAIL awfirst_bresp: got %b expected %b", {bvalid, bresp}, 3'b100);
    end
    testsRun++;
    if (regs[127:96] !== 32'hCAFE_F00D) begin
      testsFailed++; $display("[TB] FAIL awfirst_reg3: got %h expected %h", regs[127:96], 32'hCAFE_F00D);
    end
    testsRun++;
    if (regs[31:0] !== 32'h0) begin
      testsFailed++; $display("[TB] FAIL awfirst_reg0_untouched: got %h expected %h", regs[31:0], 32'h0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_errors_and_id();
    logic [1:0] resp;
    doWrite(32'h1C, 32'hFFFF_FFFF, 4'hF, resp);
    testsRun++;
    if (resp !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL id_write_bresp: got %b expected %b", resp, 2'b10);
    end
    testsRun++;
    if (regs[255:224] !== 32'hA11E_0001) begin
      testsFailed++; $display("[TB] FAIL id_write_value: got %h expected %h", regs[255:224], 32'hA11E_0001);
    end
    doWrite(32'h05, 32'h0000_0000, 4'hF, resp);
    testsRun++;
    if ({resp, regs[63:32]} !== {2'b10, 32'hDEAD_BEEF}) begin
      testsFailed++; $display("[TB] FAIL misaligned_write: got %h expected %h", {resp, regs[63:32]}, {2'b10, 32'hDEAD_BEEF});
    end
    doWrite(32'h20, 32'h0000_0000, 4'hF, resp);
    testsRun++;
    if (resp !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL range_write_bresp: got %b expected %b", resp, 2'b10);
    end
    arvalid = 1'b1; araddr = 32'h1C;
    tick();
    arvalid = 1'b0;
    testsRun++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hA11E_0001}) begin
      testsFailed++; $display("[TB] FAIL id_read: got %h expected %h", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hA11E_0001});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    testsRun++;
    if ({rvalid, arready} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL id_read_release: got %b expected %b", {rvalid, arready}, 2'b01);
    end
    arvalid = 1'b1; araddr = 32'h0C;
    tick();
    arvalid = 1'b0;
    testsRun++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
      testsFailed++; $display("[TB] FAIL reg3_read: got %h expected %h", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hCAFE_F00D});
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_read_slverr();
    arvalid = 1'b1; araddr = 32'h40;
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      testsRun++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b10, 32'h0}) begin
        testsFailed++; $display("[TB] FAIL slverr_hold_%0d: got %h expected %h", c, {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b10, 32'h0});
      end
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    testsRun++;
    if ({rvalid, arready} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL slverr_release: got %b expected %b", {rvalid, arready}, 2'b01);
    end
  endtask

  task automatic test_read_during_write();
    awvalid = 1'b1; awaddr = 32'h04; wvalid = 1'b1; wdata = 32'h0102_0304; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h04;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    testsRun++;
    if ({rvalid, rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
      testsFailed++; $display("[TB] FAIL rdw_old_value: got %h expected %h", {rvalid, rdata}, {1'b1, 32'hDEAD_BEEF});
    end
    testsRun++;
    if ({bvalid, regs[63:32]} !== {1'b1, 32'h0102_0304}) begin
      testsFailed++; $display("[TB] FAIL rdw_new_value: got %h expected %h", {bvalid, regs[63:32]}, {1'b1, 32'h0102_0304});
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    testsRun++;
    if ({bvalid, rvalid} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL rdw_release: got %b expected %b", {bvalid, rvalid}, 2'b00);
    end
  endtask

  task automatic test_wstrb();
    logic [1:0]  resp;
    logic [31:0] expected;
    doWrite(32'h00, 32'h1122_3344, 4'hF, resp);
    doWrite(32'h00, 32'hAABB_CCDD, 4'b0101, resp);
`ifdef AXI4_LITE_SLV_WSTRB_EN
    expected = 32'h11BB_33DD;
`else
    expected = 32'hAABB_CCDD;
`endif
    testsRun++;
    if ({resp, regs[31:0]} !== {2'b00, expected}) begin
      testsFailed++; $display("[TB] FAIL wstrb_partial: got %h expected %h", {resp, regs[31:0]}, {2'b00, expected});
    end
    doWrite(32'h00, 32'h0000_0000, 4'h0, resp);
`ifdef AXI4_LITE_SLV_WSTRB_EN
    expected = 32'h11BB_33DD;
`else
    expected = 32'h0000_0000;
`endif
    testsRun++;
    if ({resp, regs[31:0]} !== {2'b00, expected}) begin
      testsFailed++; $display("[TB] FAIL wstrb_zero: got %h expected %h", {resp, regs[31:0]}, {2'b00, expected});
    end
  endtask

  task automatic test_reset_mid();
    awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h55AA_55AA; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    testsRun++;
    if ({bvalid, regs[159:128]} !== {1'b1, 32'h55AA_55AA}) begin
      testsFailed++; $display("[TB] FAIL midrst_commit: got %h expected %h", {bvalid, regs[159:128]}, {1'b1, 32'h55AA_55AA});
    end
    rst = 1'b1;
    tick();
    testsRun++;
    if ({bvalid, regs[159:128], regs[63:32]} !== {1'b0, 32'h0, 32'h0}) begin
      testsFailed++; $display("[TB] FAIL midrst_wresp: got %h expected %h", {bvalid, regs[159:128], regs[63:32]}, {1'b0, 32'h0, 32'h0});
    end
    rst = 1'b0;
    tick();
    // Park a W beat, then reset: the held data must be discarded.
    wvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    testsRun++;
    if ({awready, wready, arready} !== 3'b111) begin
      testsFailed++; $display("[TB] FAIL midrst_readys: got %b expected %b", {awready, wready, arready}, 3'b111);
    end
    awvalid = 1'b1; awaddr = 32'h0C;
    tick();
    awvalid = 1'b0;
    testsRun++;
    if ({bvalid, wready, regs[127:96]} !== {1'b0, 1'b1, 32'h0}) begin
      testsFailed++; $display("[TB] FAIL midrst_abandoned: got %h expected %h", {bvalid, wready, regs[127:96]}, {1'b0, 1'b1, 32'h0});
    end
    wvalid = 1'b1; wdata = 32'h0BAD_C0DE;
    tick();
    wvalid = 1'b0;
    testsRun++;
    if ({bvalid, regs[127:96]} !== {1'b1, 32'h0BAD_C0DE}) begin
      testsFailed++; $display("[TB] FAIL midrst_after: got %h expected %h", {bvalid, regs[127:96]}, {1'b1, 32'h0BAD_C0DE});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_same_cycle();
    test_w_first();
    test_aw_first();
    test_errors_and_id();
    test_read_slverr();
    test_read_during_write();
    test_wstrb();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning number of 32-bit registers (index 0..NUM_REGS-1; NUM_REGS-1 is read-only ID).
REQ-002 SHALL have parameter ID_VALUE, default 32'hA11E_0001, meaning constant returned by ID register.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 awvalid/awready  input/output  1/1  write address handshake; awaddr  input  32  byte address.
REQ-006 wvalid/wready  input/output  1/1  write data handshake; wdata  input  32; wstrb  input  4  byte enables.
REQ-007 bvalid  output  1; bready  input  1; bresp  output  2  write response (00 OKAY, 10 SLVERR).
REQ-008 arvalid/arready  input/output  1/1  read address handshake; araddr  input  32.
REQ-009 rvalid  output  1; rready  input  1; rdata  output  32; rresp  output  2.
REQ-010 regs_o  output  NUM_REGS*32  current register contents, index 0 in LSBs.

Function
REQ-011 Decode: index = addr[31:2]; access SHALL be SLVERR if addr[1:0]!=0 or index>=NUM_REGS.
REQ-012 Write FSM states: W_IDLE, W_WAIT_W (AW held), W_WAIT_AW (W held), W_RESP.
REQ-013 awready SHALL be high only in W_IDLE or W_WAIT_AW; wready only in W_IDLE or W_WAIT_W; AW and W accepted in either order or same cycle.
REQ-014 On the edge completing the second of AW/W handshakes, register SHALL update and FSM SHALL enter W_RESP; bvalid high the following cycle (1-cycle latency from last handshake).
REQ-015 In W_RESP bvalid and bresp SHALL hold stable until bready; on bvalid&&bready FSM SHALL return to W_IDLE, bvalid low next cycle; no new AW/W accepted during W_RESP.
REQ-016 Write to ID register or SLVERR address SHALL not modify any register and SHALL return bresp=10.
REQ-017 Read FSM states: R_IDLE, R_RESP; arready SHALL equal (state==R_IDLE).
REQ-018 On arvalid&&arready, rdata/rresp SHALL be registered and rvalid high next cycle; held stable until rready; rdata=0 with rresp=10 on SLVERR.
REQ-019 Simultaneous read handshake and write commit to same index SHALL return pre-write value.
REQ-020 Read and write paths SHALL be independent; one outstanding transaction per path.
REQ-021 awvalid/wvalid/arvalid SHALL be ignored while their ready is low.

Reset
REQ-022 While rst is high at a clk edge: registers 0..NUM_REGS-2 = 0, FSMs to idle, awready/wready/arready = 0 during reset, bvalid/rvalid = 0, bresp/rresp = 00, rdata = 0.
REQ-023 Reset mid-transaction SHALL abandon it with no register update; first cycle after deassertion awready/wready/arready = 1.

Configuration
REQ-024 Macro AXI4_LITE_SLV_WSTRB_EN defined: byte lane i written only when wstrb[i]=1; wstrb=0 SHALL complete with OKAY and no change.
REQ-025 Macro undefined: wstrb ignored, full 32-bit word written on every OKAY write.

Structure
REQ-026 Shared package axi4_lite_pkg SHALL hold resp_e enum (OKAY=2'b00, SLVERR=2'b10), write/read state enums, and default ID constant.
REQ-027 One sub-module axi4_lite_addr_decode (address -> index, error flag) SHALL be instantiated once per path.

Verification
REQ-028 AW and W same cycle, addr 0x04, wdata 0xDEADBEEF, wstrb F -> bvalid next cycle, bresp 00, regs_o[63:32]=0xDEADBEEF.
REQ-029 W at cycle 0, AW at cycle 3, addr 0x08 -> wready low cycles 1-3, bvalid cycle 4, bresp 00.
REQ-030 Write 0x1C (ID) -> bresp 10; read 0x1C -> rdata 0xA11E0001, rresp 00.
REQ-031 Read 0x40 with rready low 5 cycles -> rvalid held, rdata 0, rresp 10, arready low until rready.
REQ-032 WSTRB_EN defined, reg0=0x11223344, write 0xAABBCCDD wstrb 0101 -> reg0=0x11BB33DD.
REQ-033 rst asserted during W_RESP -> bvalid low next cycle, register retains committed value except reset to 0.
